// File: rtl/auto_pkg.sv
// Shared encodings for the autonomous-drive controller: phase codes, drive
// direction one-hots (same bit order as the obstacle detector) and the mode code.
package auto_pkg;

    localparam logic [1:0] PH_WAIT   = 2'b00;
    localparam logic [1:0] PH_TURN   = 2'b01;
    localparam logic [1:0] PH_MOVE   = 2'b10;
    localparam logic [1:0] PH_DECIDE = 2'b11;

    localparam logic [3:0] DIR_NONE = 4'b0000;
    localparam logic [3:0] DIR_F    = 4'b0001;
    localparam logic [3:0] DIR_B    = 4'b0010;
    localparam logic [3:0] DIR_L    = 4'b0100;
    localparam logic [3:0] DIR_R    = 4'b1000;

    localparam logic [1:0] AUTO_MODE = 2'b11;

endpackage

// File: rtl/auto_pilot_debounce.sv
// Four-way obstacle detector debouncer: det follows the raw flags only after
// DEB_CYCLES consecutive identical registered samples that differ from det.
module detector_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic [3:0] raw,
    output logic [3:0] det
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam logic [CW-1:0] RUN_LAST = (DEB_CYCLES > 1) ? CW'(DEB_CYCLES - 1) : '0;

    logic [3:0]    smp;
    logic [3:0]    cand;
    logic [CW-1:0] run;

    // cand always tracks the previous sample, so run is the length of the
    // current streak of a value that differs from det.
    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            smp  <= '1;
            cand <= '1;
            det  <= '1;
            run  <= '0;
        end else begin
            smp <= raw;
            if (smp == det) begin
                cand <= det;
                run  <= '0;
            end else if (smp != cand) begin
                cand <= smp;
                run  <= CW'(1);
                if (DEB_CYCLES <= 1) begin
                    det <= smp;
                end
            end else if (run >= RUN_LAST) begin
                det <= smp;
                run <= '0;
            end else begin
                run <= run + CW'(1);
            end
        end
    end

endmodule

// File: rtl/auto_pilot.sv
// Autonomous maze-drive controller: debounced wall sensing, wall-follow
// direction choice and tick-timed WAIT/DECIDE/TURN/MOVE sequencing with beacons.
module auto_pilot
    import auto_pkg::*;
#(
    parameter int TICK_DIV   = 2_000_000,
    parameter int WAIT_TICKS = 1,
    parameter int TURN_TICKS = 5,
    parameter int MOVE_TICKS = 3,
    parameter int DEB_CYCLES = 16,
    parameter int BCNT_W     = 4
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              power,
    input  logic [1:0]        global_state,
    input  logic              hand_mode,
    input  logic [3:0]        turn_detector,
    output logic [1:0]        next_state,
    output logic [3:0]        next_moving_state,
    output logic              pl_beacon_sig,
    output logic              de_beacon_sig,
    output logic [BCNT_W-1:0] beacon_cnt
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MAX_T0 = (WAIT_TICKS > MOVE_TICKS) ? WAIT_TICKS : MOVE_TICKS;
    localparam int MAX_T  = (MAX_T0 > 2 * TURN_TICKS) ? MAX_T0 : 2 * TURN_TICKS;
    localparam int TCW = $clog2(MAX_T + 1);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [TCW-1:0]   WAIT_LAST  = TCW'(WAIT_TICKS - 1);
    localparam logic [TCW-1:0]   TURN_LAST  = TCW'(TURN_TICKS - 1);
    localparam logic [TCW-1:0]   UTURN_LAST = TCW'(2 * TURN_TICKS - 1);
    localparam logic [TCW-1:0]   MOVE_LAST  = TCW'(MOVE_TICKS - 1);

    logic              en;
    logic [3:0]        det;
    logic [3:0]        open;
    logic [3:0]        sel;
    logic              fork_pt;
    logic              dead_end;
    logic [1:0]        phase;
    logic [3:0]        mov;
    logic [3:0]        choice;
    logic              pl;
    logic              de;
    logic [BCNT_W-1:0] bcnt;
    logic [DIV_W-1:0]  div;
    logic [TCW-1:0]    tcnt;
    logic [TCW-1:0]    cur_last;
    logic              tick;
    logic              phase_done;

    detector_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
        .sys_clk(sys_clk),
        .rst    (rst),
        .raw    (turn_detector),
        .det    (det)
    );

    assign en = power && (global_state == AUTO_MODE);

    always_comb begin
        open = ~det;
        sel  = DIR_NONE;
        if (hand_mode) begin
            if (open[2])      sel = DIR_L;
            else if (open[0]) sel = DIR_F;
            else if (open[3]) sel = DIR_R;
            else if (open[1]) sel = DIR_B;
        end else begin
            if (open[3])      sel = DIR_R;
            else if (open[0]) sel = DIR_F;
            else if (open[2]) sel = DIR_L;
            else if (open[1]) sel = DIR_B;
        end
        fork_pt  = (open[0] & open[2]) | (open[0] & open[3]) | (open[2] & open[3]);
        dead_end = (open == DIR_B);
    end

    always_comb begin
        case (phase)
            PH_WAIT: cur_last = WAIT_LAST;
            PH_TURN: cur_last = (choice == DIR_B) ? UTURN_LAST : TURN_LAST;
            default: cur_last = MOVE_LAST;
        endcase
    end

    assign tick       = (div == DIV_LAST);
    assign phase_done = tick && (tcnt == cur_last);

    // The decision is taken on the edge that enters DECIDE so the beacon
    // pulses line up with the single cycle next_state reads DECIDE.
    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            phase  <= PH_WAIT;
            mov    <= DIR_NONE;
            choice <= DIR_NONE;
            pl     <= 1'b0;
            de     <= 1'b0;
            bcnt   <= '0;
            div    <= '0;
            tcnt   <= '0;
        end else if (!en) begin
            phase <= PH_WAIT;
            mov   <= DIR_NONE;
            pl    <= 1'b0;
            de    <= 1'b0;
            div   <= '0;
            tcnt  <= '0;
        end else begin
            pl <= 1'b0;
            de <= 1'b0;
            if (phase == PH_DECIDE) begin
                div  <= '0;
                tcnt <= '0;
                if (choice == DIR_NONE) begin
                    phase <= PH_WAIT;
                    mov   <= DIR_NONE;
                end else if (choice == DIR_F) begin
                    phase <= PH_MOVE;
                    mov   <= DIR_F;
                end else begin
                    phase <= PH_TURN;
                    mov   <= choice;
                end
            end else if (phase_done) begin
                div  <= '0;
                tcnt <= '0;
                case (phase)
                    PH_WAIT: begin
                        phase  <= PH_DECIDE;
                        mov    <= DIR_NONE;
                        choice <= sel;
                        pl     <= fork_pt;
                        de     <= dead_end;
                        if (fork_pt && (bcnt != '1)) begin
                            bcnt <= bcnt + BCNT_W'(1);
                        end
                    end
                    PH_TURN: begin
                        phase <= PH_MOVE;
                        mov   <= DIR_F;
                    end
                    default: begin
                        phase <= PH_WAIT;
                        mov   <= DIR_NONE;
                    end
                endcase
            end else begin
                div <= tick ? '0 : div + DIV_W'(1);
                if (tick) begin
                    tcnt <= tcnt + TCW'(1);
                end
            end
        end
    end

    assign next_state        = phase;
    assign next_moving_state = mov;
    assign pl_beacon_sig     = pl;
    assign de_beacon_sig     = de;
    assign beacon_cnt        = bcnt;

endmodule

// File: tb/tb_auto_pilot.sv
// Self-checking bench for auto_pilot: cycle-accurate reference model compared
// every cycle, a table of decision vectors, and directed multi-cycle corners.
module tb_auto_pilot;

    localparam int TD = 4;
    localparam int WT = 1;
    localparam int TT = 2;
    localparam int MT = 3;
    localparam int DB = 2;
    localparam int BW = 4;

    logic          sys_clk = 1'b0;
    logic          rst = 1'b0;
    logic          power = 1'b0;
    logic [1:0]    global_state = 2'b00;
    logic          hand_mode = 1'b0;
    logic [3:0]    turn_detector = 4'hF;
    logic [1:0]    next_state;
    logic [3:0]    next_moving_state;
    logic          pl_beacon_sig;
    logic          de_beacon_sig;
    logic [BW-1:0] beacon_cnt;

    auto_pilot #(
        .TICK_DIV  (TD),
        .WAIT_TICKS(WT),
        .TURN_TICKS(TT),
        .MOVE_TICKS(MT),
        .DEB_CYCLES(DB),
        .BCNT_W    (BW)
    ) dut (
        .sys_clk          (sys_clk),
        .rst              (rst),
        .power            (power),
        .global_state     (global_state),
        .hand_mode        (hand_mode),
        .turn_detector    (turn_detector),
        .next_state       (next_state),
        .next_moving_state(next_moving_state),
        .pl_beacon_sig    (pl_beacon_sig),
        .de_beacon_sig    (de_beacon_sig),
        .beacon_cnt       (beacon_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: each phase is a countdown of remaining cycles.
    int         m_phase;
    int         m_left;
    int         m_bcnt;
    logic [3:0] m_mov;
    logic [3:0] m_det;
    logic [3:0] m_dir;
    bit         m_pl;
    bit         m_de;
    logic [3:0] hist[$];

    function automatic void model_decide();
        logic [3:0] open;
        int order[4];
        int nf;
        open = ~m_det;
        if (hand_mode) order = '{2, 0, 3, 1};
        else           order = '{3, 0, 2, 1};
        m_dir = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            if (open[order[k]]) begin
                m_dir = 4'(1 << order[k]);
                break;
            end
        end
        nf = int'(open[0]) + int'(open[2]) + int'(open[3]);
        if (nf >= 2) begin
            m_pl = 1'b1;
            if (m_bcnt < (1 << BW) - 1) m_bcnt++;
        end
        if (open == 4'b0010) m_de = 1'b1;
    endfunction

    function automatic void model_step();
        bit same;
        if (!rst) begin
            m_phase = 0; m_left = WT * TD; m_mov = 4'b0000; m_dir = 4'b0000;
            m_pl = 1'b0; m_de = 1'b0; m_bcnt = 0; m_det = 4'hF;
            hist.delete();
            hist.push_back(4'hF);
            return;
        end
        if (!(power && global_state == 2'b11)) begin
            m_phase = 0; m_left = WT * TD; m_mov = 4'b0000; m_pl = 1'b0; m_de = 1'b0;
        end else begin
            m_pl = 1'b0;
            m_de = 1'b0;
            case (m_phase)
                0: begin
                    m_left--;
                    if (m_left == 0) begin
                        model_decide();
                        m_phase = 3;
                        m_mov = 4'b0000;
                    end
                end
                3: begin
                    if (m_dir == 4'b0000) begin
                        m_phase = 0; m_left = WT * TD; m_mov = 4'b0000;
                    end else if (m_dir == 4'b0001) begin
                        m_phase = 2; m_left = MT * TD; m_mov = 4'b0001;
                    end else begin
                        m_phase = 1; m_mov = m_dir;
                        m_left = ((m_dir == 4'b0010) ? 2 * TT : TT) * TD;
                    end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 2; m_left = MT * TD; m_mov = 4'b0001;
                    end
                end
                default: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 0; m_left = WT * TD; m_mov = 4'b0000;
                    end
                end
            endcase
        end
        // det adopts a value once the last DB samples all agree on it
        if (hist.size() >= DB) begin
            same = 1'b1;
            for (int k = hist.size() - DB; k < hist.size(); k++)
                if (hist[k] != hist[hist.size() - 1]) same = 1'b0;
            if (same && hist[hist.size() - 1] != m_det) m_det = hist[hist.size() - 1];
        end
        hist.push_back(turn_detector);
        while (hist.size() > DB) void'(hist.pop_front());
    endfunction

    task automatic cycle();
        @(posedge sys_clk);
        model_step();
        @(negedge sys_clk);
        check("state", int'(next_state), m_phase);
        check("move", int'(next_moving_state), int'(m_mov));
        check("pl_pulse", int'(pl_beacon_sig), int'(m_pl));
        check("de_pulse", int'(de_beacon_sig), int'(m_de));
        check("bcnt", int'(beacon_cnt), m_bcnt);
    endtask

    task automatic wait_state(input logic [1:0] st, input int limit, output bit ok);
        int n;
        n = 0;
        while (next_state != st && n < limit) begin
            cycle();
            n++;
        end
        ok = (next_state == st);
        if (!ok) check("wait_timeout", 0, 1);
    endtask

    typedef struct {
        logic [3:0] det;
        bit         hand;
        logic [3:0] dir;
        bit         pl;
        bit         de;
        int         turn_cyc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        bit ok;
        int n;
        int b0;

        vecs[0] = '{4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 0};
        vecs[1] = '{4'b0101, 1'b0, 4'b1000, 1'b0, 1'b0, 8};
        vecs[2] = '{4'b0000, 1'b1, 4'b0100, 1'b1, 1'b0, 8};
        vecs[3] = '{4'b1101, 1'b0, 4'b0010, 1'b0, 1'b1, 16};
        vecs[4] = '{4'b0000, 1'b0, 4'b1000, 1'b1, 1'b0, 8};
        vecs[5] = '{4'b1100, 1'b0, 4'b0001, 1'b0, 1'b0, 0};
        vecs[6] = '{4'b0110, 1'b1, 4'b0001, 1'b1, 1'b0, 0};
        vecs[7] = '{4'b0011, 1'b0, 4'b1000, 1'b1, 1'b0, 8};

        // reset values
        @(negedge sys_clk);
        rst = 1'b0;
        cycle();
        check("rst_state", int'(next_state), 0);
        check("rst_move", int'(next_moving_state), 0);
        check("rst_bcnt", int'(beacon_cnt), 0);

        // all blocked: WAIT x4, DECIDE x1, repeating
        rst = 1'b1; power = 1'b1; global_state = 2'b11;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            check("idle_alt", int'(next_state), (i % 5 == 4) ? 3 : 0);
            check("idle_move", int'(next_moving_state), 0);
            check("idle_pl", int'(pl_beacon_sig), 0);
        end

        // decision table
        foreach (vecs[i]) begin
            power = 1'b0;
            turn_detector = vecs[i].det;
            hand_mode = vecs[i].hand;
            for (int k = 0; k < DB + 3; k++) cycle();
            power = 1'b1;
            b0 = int'(beacon_cnt);
            wait_state(2'b11, 20, ok);
            if (ok) begin
                check("vec_pl", int'(pl_beacon_sig), int'(vecs[i].pl));
                check("vec_de", int'(de_beacon_sig), int'(vecs[i].de));
                check("vec_bcnt", int'(beacon_cnt), b0 + int'(vecs[i].pl));
                cycle();
                if (vecs[i].dir == 4'b0000) begin
                    check("vec_blocked", int'(next_state), 0);
                end else begin
                    n = 0;
                    while (next_state == 2'b01 && next_moving_state == vecs[i].dir && n < 40) begin
                        n++;
                        cycle();
                    end
                    check("vec_turn_len", n, vecs[i].turn_cyc);
                    check("vec_move_st", int'(next_state), 2);
                    check("vec_move_dir", int'(next_moving_state), 1);
                    n = 0;
                    while (next_state == 2'b10 && n < 40) begin
                        n++;
                        cycle();
                    end
                    check("vec_move_len", n, MT * TD);
                    check("vec_after_move", int'(next_state), 0);
                end
            end
        end

        // power drop in the 3rd TURN cycle
        power = 1'b0; turn_detector = 4'b0101; hand_mode = 1'b0;
        for (int k = 0; k < DB + 3; k++) cycle();
        power = 1'b1;
        wait_state(2'b01, 30, ok);
        if (ok) begin
            b0 = int'(beacon_cnt);
            cycle();
            cycle();
            check("drop_pre", int'(next_state), 1);
            power = 1'b0;
            cycle();
            check("drop_state", int'(next_state), 0);
            check("drop_move", int'(next_moving_state), 0);
            check("drop_bcnt", int'(beacon_cnt), b0);
            power = 1'b1;
        end

        // beacon saturation over 16 forks
        rst = 1'b0; turn_detector = 4'b0000;
        cycle();
        rst = 1'b1;
        for (int f = 1; f <= 16; f++) begin
            wait_state(2'b11, 40, ok);
            if (ok) begin
                check("sat_pulse", int'(pl_beacon_sig), 1);
                check("sat_cnt", int'(beacon_cnt), (f < 15) ? f : 15);
            end
            cycle();
        end

        // randomized traffic against the model
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 5) == 0) turn_detector = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) hand_mode = ~hand_mode;
            if ($urandom_range(0, 59) == 0) power = ~power;
            if ($urandom_range(0, 79) == 0) global_state = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) global_state = 2'b11;
            if (!power && $urandom_range(0, 19) == 0) power = 1'b1;
            rst = ($urandom_range(0, 499) != 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/auto_pilot.md
# auto_pilot

Parametrised autonomous-drive controller for the maze car, the successor of the fixed-period auto block. It is active only when `power` is on and `global_state` is 2'b11 (auto mode). It debounces the four-way obstacle detector and selects a direction by a configurable wall-follow rule. It then sequences WAIT/DECIDE/TURN/MOVE phases with exact tick-based durations, emits beacon place/destroy signals, and keeps a saturating beacon count. Outputs feed the global drive mux alongside the manual and semi-auto controllers.

## Interface
- `TICK_DIV`, 2_000_000: sys_clk cycles per phase tick (20 ms at 100 MHz)
- `WAIT_TICKS`, 1: ticks spent in WAIT
- `TURN_TICKS`, 5: ticks for a 90° turn; a 180° turn takes 2*TURN_TICKS
- `MOVE_TICKS`, 3: ticks of forward motion per step
- `DEB_CYCLES`, 16: consecutive stable sys_clk cycles before a detector change is accepted
- `BCNT_W`, 4: beacon counter width
- `sys_clk`  in  1  single clock; all logic on posedge
- `rst`  in  1  reset, synchronous, active-low
- `power`  in  1  1 = powered
- `global_state`  in  2  2'b11 = auto mode
- `hand_mode`  in  1  0 = right-hand rule, 1 = left-hand rule; sampled only in DECIDE
- `turn_detector`  in  4  blocked flags, 1 = wall; bit0 front, bit1 back, bit2 left, bit3 right
- `next_state`  out  2  phase: WAIT 00, TURN 01, MOVE 10, DECIDE 11
- `next_moving_state`  out  4  one-hot drive command with the same bit order as the detector; 0000 = stop
- `pl_beacon_sig`  out  1  one-cycle pulse: place beacon
- `de_beacon_sig`  out  1  one-cycle pulse: destroy beacon at dead end
- `beacon_cnt`  out  BCNT_W  beacons placed, saturating

## Operation
- Enable: en = power & (global_state==2'b11).
  - When en=0: phase is forced to WAIT, tick divider and phase counter are cleared, and both beacon pulses are 0.
  - `beacon_cnt` holds; only `rst` clears it.
  - Resumption starts a fresh WAIT.
- Debounce: `det` updates to raw `turn_detector` after DEB_CYCLES consecutive identical samples. It runs regardless of en. Reset value of `det` is 4'b1111.
- WAIT: output 0000. After WAIT_TICKS ticks, go to DECIDE.
- DECIDE lasts exactly one cycle and outputs 0000. With open = ~det:
  - Right-hand priority is right, front, left, back. Left-hand priority is left, front, right, back. The first open direction is chosen.
  - Fork: if ≥2 of {front, left, right} are open, pulse `pl_beacon_sig` and increment `beacon_cnt`, saturating at all-ones.
  - Dead end: if only back is open, pulse `de_beacon_sig` and choose back.
  - All four blocked: no pulse, return to WAIT.
  - If the choice is front, go directly to MOVE; otherwise go to TURN.
- TURN: output the chosen direction for TURN_TICKS ticks (2*TURN_TICKS for back), then go to MOVE.
- MOVE: output 0001 (front) for MOVE_TICKS ticks, then go to WAIT.
- Tick divider: clears on every phase entry, so each phase lasts exactly N*TICK_DIV cycles.

## Timing
- Reset (rst=0 at a clock edge): on the next edge, next_state=00, next_moving_state=0000, both pulses 0, beacon_cnt=0, divider and phase counter 0, `det`=1111.
- All outputs are registered and change on the cycle the phase transition is registered.
- Beacon pulses are high in the single cycle that next_state=11.
- Detector latency: a raw change becomes visible to DECIDE DEB_CYCLES+1 cycles later.
- en dropping mid-TURN or mid-MOVE takes effect on the next edge: output 0000, WAIT.
- rst has priority over en.
- An already-saturated `beacon_cnt` stays at its maximum, but `pl_beacon_sig` still pulses.

## Structure
- Package `auto_pkg`:
  - phase encodings WAIT/TURN/MOVE/DECIDE
  - direction one-hots DIR_F/B/L/R
  - AUTO_MODE = 2'b11
- Sub-module `detector_debounce`: 4-bit, parameter DEB_CYCLES, with sys_clk/rst.
- The FSM, tick divider and priority selector stay in `auto_pilot`.

## Test plan
Scenarios run with TICK_DIV=4, WAIT_TICKS=1, TURN_TICKS=2, MOVE_TICKS=3, DEB_CYCLES=2.
- Reset, then en=1 with det=1111: next_state alternates 00 (4 cycles) and 11 (1 cycle); outputs 0000; no pulses.
- det=0101 (right and back open), hand_mode=0: DECIDE chooses 1000, TURN outputs 1000 for 8 cycles, MOVE outputs 0001 for 12 cycles, then WAIT; no beacon.
- det=0000, hand_mode=1: one `pl_beacon_sig` pulse, beacon_cnt 0→1, TURN outputs 0100.
- det=1101 (only back open): `de_beacon_sig` pulses, TURN outputs 0010 for 16 cycles.
- Set power=0 in the 3rd TURN cycle: next edge gives next_state=00 and output 0000; beacon_cnt is unchanged.
- 16 fork decisions with BCNT_W=4: beacon_cnt holds at 15, and the 16th pulse still occurs.
